otbn_rf_bignum_mp: RTL and testbench
====================================

// Module: otbn_rf_bignum_mp
// PURPOSE
//  Parametrised multi-port wide register file (WDRs) for OTBN bignum datapath, FPGA RAM-inferable.
//  Two independent write ports with per-lane enables; NumRdPorts async read ports.
//  Built-in wipe FSM zeroes all rows after reset and on request.
//  Integrity gen/check stays in the wrapping otbn_rf_bignum.
// PARAMETERS
//  Depth       32   number of rows (NWdr)
//  DataW       312  row width incl. integrity bits (ExtWLEN)
//  NumLanes    8    write-enable lanes per row; LaneW = DataW/NumLanes, must divide exactly (elab assert)
//  NumRdPorts  2    number of async read ports
//  AddrW       $clog2(Depth)  derived, not overridable
// PORTS
//  clk_i           in   1                      clock
//  rst_ni          in   1                      async active-low reset
//  wr_addr_a_i     in   AddrW                  write port A row address
//  wr_en_a_i       in   NumLanes               write port A lane enables
//  wr_data_a_i     in   DataW                  write port A data
//  wr_addr_b_i     in   AddrW                  write port B row address
//  wr_en_b_i       in   NumLanes               write port B lane enables
//  wr_data_b_i     in   DataW                  write port B data
//  rd_addr_i       in   NumRdPorts x AddrW     read addresses
//  rd_data_o       out  NumRdPorts x DataW     read data, combinational from array
//  wipe_req_i      in   1                      request full wipe (level, sampled when idle)
//  wipe_busy_o     out  1                      wipe in progress; writes dropped
//  wipe_done_o     out  1                      1-cycle pulse after last row wiped
//  wr_collision_o  out  1                      registered pulse: A/B hit same row+lane last cycle
// BEHAVIOUR
//  Reset (async assert): FSM -> WipeBusy, counter=0, wipe_busy_o=1, wipe_done_o=0, wr_collision_o=0.
//   Storage is not reset; rd_data_o undefined until first wipe completes.
//  Writes: synchronous, posedge. Lane l of row addr gets data[l*LaneW +: LaneW] when en[l]=1.
//   A and B different rows: both write same cycle. Same row, disjoint lanes: both write (merge).
//   Same row, overlapping lane: port A wins that lane; B's other lanes still written;
//   wr_collision_o=1 next cycle, else 0.
//   Address >= Depth (non-pow2 Depth): write dropped, read returns 0.
//  Reads: async, no write bypass; write at edge N visible on rd_data_o after edge N.
//  Wipe FSM (wipe_state_e): WipeIdle, WipeBusy, WipeDone.
//   WipeIdle: wipe_req_i=1 -> WipeBusy, counter=0.
//   WipeBusy: each cycle row[counter] <= 0 (all lanes), counter++; counter==Depth-1 -> WipeDone.
//    External writes ignored (no collision flag); wipe_req_i ignored, no restart.
//   WipeDone: wipe_done_o=1 one cycle, busy=0 -> WipeIdle.
//    wipe_req_i held high re-arms wipe from WipeIdle next cycle.
//  Wipe duration: Depth cycles busy + 1 done cycle.
//  Reset mid-wipe restarts wipe from row 0.
//  Reads during wipe return current (partially wiped) contents.
// STRUCTURE
//  otbn_pkg: add typedef enum logic [1:0] wipe_state_e; reuse NWdr, ExtWLEN, WdrAw as defaults.
//  Sub-module otbn_rf_bignum_wipe_ctrl: FSM + row counter.
//   Outputs: wipe_we, wipe_addr, busy, done.
//  Top: write-merge/priority logic, array, read muxes, collision register.
//  Array written in one always_ff per lane so tools infer lane-enabled RAM (RAM32M on Xilinx).
// TESTING
//  Release reset, idle 33 cycles:
//   -> busy=1 for 32 cycles, done pulse at cycle 33.
//   -> all rows read 0 on both ports.
//  A: addr 5, en 0xFF, data all-ones; B: addr 9, en 0x0F, data 0x..A5 pattern.
//   -> row5 all ones; row9 low 4 lanes pattern, high lanes 0; collision 0.
//  A and B same cycle, addr 3, en_a 0x03, en_b 0x06, distinct data.
//   -> lanes0-1 from A, lane2 from B; collision=1 next cycle only.
//  Write row 7 (en 0xFF), pulse wipe_req_i, attempt write row 7 during busy.
//   -> row 7 reads 0 after done; busy exactly 32 cycles.
//  Assert rst_ni at wipe counter 10, release.
//   -> wipe restarts at row 0, 32 busy cycles, one done pulse.
//  Depth=24, NumRdPorts=3 config:
//   -> write addr 30 dropped; read addr 30 returns 0; third port matches.

Source files
------------

// File: rtl/otbn_pkg.sv
// Shared OTBN bignum constants and the register-file wipe controller state encoding.
package otbn_pkg;

  localparam int NWdr    = 32;
  localparam int ExtWLEN = 312;
  localparam int WdrAw   = $clog2(NWdr);

  typedef enum logic [1:0] {
    WipeIdle = 2'd0,
    WipeBusy = 2'd1,
    WipeDone = 2'd2
  } wipe_state_e;

endpackage

// File: rtl/otbn_rf_bignum_wipe_ctrl.sv
// Wipe sequencer: walks every row once (one row per cycle), then pulses done for a cycle.
// Starts a wipe out of reset; further requests are only accepted while idle.
module otbn_rf_bignum_wipe_ctrl
  import otbn_pkg::*;
#(
  parameter int Depth = NWdr,
  localparam int AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wipe_req_i,
  output logic             wipe_we,
  output logic [AddrW-1:0] wipe_addr,
  output logic             busy,
  output logic             done
);

  localparam logic [AddrW-1:0] LastRow = AddrW'(Depth - 1);

  wipe_state_e      state_q, state_d;
  logic [AddrW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WipeBusy;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wipe_we = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      WipeIdle: begin
        if (wipe_req_i) begin
          state_d = WipeBusy;
          cnt_d   = '0;
        end
      end
      WipeBusy: begin
        wipe_we = 1'b1;
        busy    = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastRow) state_d = WipeDone;
      end
      WipeDone: begin
        done    = 1'b1;
        state_d = WipeIdle;
      end
      // The unused encoding falls back into a full wipe so storage is never left stale.
      default: begin
        state_d = WipeBusy;
        cnt_d   = '0;
      end
    endcase
  end

  assign wipe_addr = cnt_q;

endmodule

// File: rtl/otbn_rf_bignum_mp.sv
// Multi-port wide register file: two lane-masked write ports (A wins overlaps), async reads.
// Writes land on the clock edge; while wiping, external writes are dropped.
module otbn_rf_bignum_mp
  import otbn_pkg::*;
#(
  parameter int Depth      = NWdr,
  parameter int DataW      = ExtWLEN,
  parameter int NumLanes   = 8,
  parameter int NumRdPorts = 2,
  localparam int AddrW     = $clog2(Depth)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [AddrW-1:0]                     wr_addr_a_i,
  input  logic [NumLanes-1:0]                  wr_en_a_i,
  input  logic [DataW-1:0]                     wr_data_a_i,
  input  logic [AddrW-1:0]                     wr_addr_b_i,
  input  logic [NumLanes-1:0]                  wr_en_b_i,
  input  logic [DataW-1:0]                     wr_data_b_i,
  input  logic [NumRdPorts-1:0][AddrW-1:0]     rd_addr_i,
  output logic [NumRdPorts-1:0][DataW-1:0]     rd_data_o,
  input  logic                                 wipe_req_i,
  output logic                                 wipe_busy_o,
  output logic                                 wipe_done_o,
  output logic                                 wr_collision_o
);

  localparam int               LaneW  = DataW / NumLanes;
  localparam logic [AddrW:0]   DepthW = (AddrW + 1)'(Depth);

  if (LaneW * NumLanes != DataW) begin : g_lane_chk
    $error("DataW must be an exact multiple of NumLanes");
  end

  logic             wipe_we;
  logic [AddrW-1:0] wipe_addr;
  logic             a_ok, b_ok, coll_d, coll_q;

  otbn_rf_bignum_wipe_ctrl #(
    .Depth(Depth)
  ) u_wipe_ctrl (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wipe_req_i(wipe_req_i),
    .wipe_we   (wipe_we),
    .wipe_addr (wipe_addr),
    .busy      (wipe_busy_o),
    .done      (wipe_done_o)
  );

  // Rows past Depth only exist for non-power-of-two depths; they are never written.
  assign a_ok   = !wipe_busy_o && ({1'b0, wr_addr_a_i} < DepthW);
  assign b_ok   = !wipe_busy_o && ({1'b0, wr_addr_b_i} < DepthW);
  assign coll_d = a_ok && b_ok && (wr_addr_a_i == wr_addr_b_i) && |(wr_en_a_i & wr_en_b_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) coll_q <= 1'b0;
    else         coll_q <= coll_d;
  end

  assign wr_collision_o = coll_q;

  for (genvar l = 0; l < NumLanes; l++) begin : g_lane
    logic [LaneW-1:0] mem [Depth];

    // Port A is assigned last so it owns any lane both ports target on the same row.
    always_ff @(posedge clk_i) begin
      if (wipe_we) begin
        mem[wipe_addr] <= '0;
      end else begin
        if (b_ok && wr_en_b_i[l]) mem[wr_addr_b_i] <= wr_data_b_i[l*LaneW +: LaneW];
        if (a_ok && wr_en_a_i[l]) mem[wr_addr_a_i] <= wr_data_a_i[l*LaneW +: LaneW];
      end
    end

    for (genvar p = 0; p < NumRdPorts; p++) begin : g_rd
      assign rd_data_o[p][l*LaneW +: LaneW] =
          ({1'b0, rd_addr_i[p]} < DepthW) ? mem[rd_addr_i[p]] : '0;
    end
  end

endmodule

// File: tb/tb_otbn_rf_bignum_mp.sv
// Directed bench for otbn_rf_bignum_mp: vector table for write merging, sequences for wipe/reset.
module tb_otbn_rf_bignum_mp;

  localparam logic [38:0] LA = 39'h11_2233_4455;
  localparam logic [38:0] LB = 39'h66_7788_99AA;

  typedef struct {
    logic [4:0]   addr_a;
    logic [7:0]   en_a;
    logic [311:0] dat_a;
    logic [4:0]   addr_b;
    logic [7:0]   en_b;
    logic [311:0] dat_b;
    logic [311:0] exp_a;
    logic [311:0] exp_b;
    logic         exp_coll;
  } vec_t;

  logic               clk, rst_n;
  logic [4:0]         wr_addr_a, wr_addr_b;
  logic [7:0]         wr_en_a, wr_en_b;
  logic [311:0]       wr_data_a, wr_data_b;
  logic [1:0][4:0]    rd_addr;
  logic [1:0][311:0]  rd_data;
  logic               wipe_req, busy, done, coll;

  logic [4:0]         s_addr_a, s_addr_b;
  logic [7:0]         s_en_a, s_en_b;
  logic [311:0]       s_data_a, s_data_b;
  logic [2:0][4:0]    s_rd_addr;
  logic [2:0][311:0]  s_rd_data;
  logic               s_wipe_req, s_busy, s_done, s_coll;

  int total = 0;
  int bad   = 0;

  otbn_rf_bignum_mp dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_addr_a_i(wr_addr_a), .wr_en_a_i(wr_en_a), .wr_data_a_i(wr_data_a),
    .wr_addr_b_i(wr_addr_b), .wr_en_b_i(wr_en_b), .wr_data_b_i(wr_data_b),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .wipe_req_i(wipe_req), .wipe_busy_o(busy), .wipe_done_o(done),
    .wr_collision_o(coll)
  );

  otbn_rf_bignum_mp #(.Depth(24), .NumRdPorts(3)) dut_s (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_addr_a_i(s_addr_a), .wr_en_a_i(s_en_a), .wr_data_a_i(s_data_a),
    .wr_addr_b_i(s_addr_b), .wr_en_b_i(s_en_b), .wr_data_b_i(s_data_b),
    .rd_addr_i(s_rd_addr), .rd_data_o(s_rd_data),
    .wipe_req_i(s_wipe_req), .wipe_busy_o(s_busy), .wipe_done_o(s_done),
    .wr_collision_o(s_coll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [311:0] act, input logic [311:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Runs until the done pulse (bounded); optionally hammers row 7 from both ports while busy.
  task automatic wait_wipe(input bit attack, output int bc, output int edges, output bit cs);
    bc = 0;
    edges = 0;
    cs = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      edges++;
      cs = cs | coll;
      if (done) break;
      if (busy) bc++;
      if (attack) begin
        wr_addr_a = 5'd7;  wr_en_a = 8'hFF; wr_data_a = {312{1'b1}};
        wr_addr_b = 5'd7;  wr_en_b = 8'hFF; wr_data_b = {8{LB}};
      end
    end
    wr_en_a = '0;
    wr_en_b = '0;
  endtask

  vec_t vecs[6];
  int   bc, edges, busy_total;
  bit   cs;

  initial begin
    vecs[0] = '{5'd5,  8'hFF, {312{1'b1}}, 5'd9,  8'h0F, {39{8'hA5}},
                {312{1'b1}}, {156'b0, 4'h5, {19{8'hA5}}}, 1'b0};
    vecs[1] = '{5'd3,  8'h03, {8{LA}}, 5'd3,  8'h06, {8{LB}},
                {195'b0, LB, LA, LA}, {195'b0, LB, LA, LA}, 1'b1};
    vecs[2] = '{5'd0,  8'h80, {8{LA}}, 5'd31, 8'h01, {8{LB}},
                {LA, 273'b0}, {273'b0, LB}, 1'b0};
    vecs[3] = '{5'd12, 8'hF0, {8{LA}}, 5'd12, 8'h0F, {8{LB}},
                {{4{LA}}, {4{LB}}}, {{4{LA}}, {4{LB}}}, 1'b0};
    vecs[4] = '{5'd20, 8'hFF, {8{LA}}, 5'd20, 8'hFF, {8{LB}},
                {8{LA}}, {8{LA}}, 1'b1};
    vecs[5] = '{5'd21, 8'h0C, {8{LA}}, 5'd21, 8'h3F, {8{LB}},
                {78'b0, LB, LB, LA, LA, LB, LB}, {78'b0, LB, LB, LA, LA, LB, LB}, 1'b1};

    rst_n = 1'b0;
    wr_addr_a = '0; wr_en_a = '0; wr_data_a = '0;
    wr_addr_b = '0; wr_en_b = '0; wr_data_b = '0;
    rd_addr = '0; wipe_req = 1'b0;
    s_addr_a = '0; s_en_a = '0; s_data_a = '0;
    s_addr_b = '0; s_en_b = '0; s_data_b = '0;
    s_rd_addr = '0; s_wipe_req = 1'b0;

    #12;
    chk("reset_busy", {311'b0, busy}, 312'd1);
    chk("reset_done", {311'b0, done}, 312'd0);
    chk("reset_coll", {311'b0, coll}, 312'd0);

    @(negedge clk);
    rst_n = 1'b1;
    wait_wipe(1'b0, bc, edges, cs);
    chk("init_edges_to_done", 312'(edges), 312'd32);
    chk("init_busy_samples", 312'(bc), 312'd31);
    @(posedge clk);
    #1;
    chk("init_done_one_cycle", {310'b0, busy, done}, 312'd0);

    for (int r = 0; r < 32; r++) begin
      rd_addr[0] = 5'(r);
      rd_addr[1] = 5'(31 - r);
      #1;
      chk("init_row_zero_p0", rd_data[0], '0);
      chk("init_row_zero_p1", rd_data[1], '0);
    end

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wr_addr_a = vecs[i].addr_a; wr_en_a = vecs[i].en_a; wr_data_a = vecs[i].dat_a;
      wr_addr_b = vecs[i].addr_b; wr_en_b = vecs[i].en_b; wr_data_b = vecs[i].dat_b;
      @(posedge clk);
      #1;
      wr_en_a = '0;
      wr_en_b = '0;
      rd_addr[0] = vecs[i].addr_a;
      rd_addr[1] = vecs[i].addr_b;
      #1;
      chk($sformatf("vec%0d_row_a", i), rd_data[0], vecs[i].exp_a);
      chk($sformatf("vec%0d_row_b", i), rd_data[1], vecs[i].exp_b);
      chk($sformatf("vec%0d_coll", i), {311'b0, coll}, {311'b0, vecs[i].exp_coll});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_coll_clear", i), {311'b0, coll}, 312'd0);
    end

    // Row 7 is filled, then a requested wipe must clear it despite writes attempted while busy.
    @(negedge clk);
    wr_addr_a = 5'd7; wr_en_a = 8'hFF; wr_data_a = {8{LA}};
    @(posedge clk);
    #1;
    wr_en_a = '0;
    rd_addr[0] = 5'd7;
    #1;
    chk("row7_written", rd_data[0], {8{LA}});
    @(negedge clk);
    wipe_req = 1'b1;
    @(posedge clk);
    #1;
    wipe_req = 1'b0;
    busy_total = busy ? 1 : 0;
    wr_addr_a = 5'd7; wr_en_a = 8'hFF; wr_data_a = {312{1'b1}};
    wr_addr_b = 5'd7; wr_en_b = 8'hFF; wr_data_b = {8{LB}};
    wait_wipe(1'b1, bc, edges, cs);
    busy_total += bc;
    chk("req_busy_cycles", 312'(busy_total), 312'd32);
    chk("req_edges_to_done", 312'(edges), 312'd32);
    chk("req_no_coll_while_busy", {311'b0, cs}, 312'd0);
    rd_addr[0] = 5'd7;
    #1;
    chk("row7_wiped", rd_data[0], '0);
    @(posedge clk);
    #1;
    chk("req_done_one_cycle", {310'b0, busy, done}, 312'd0);

    // Reset lands with the wipe counter at 10; the wipe must run again in full.
    @(negedge clk);
    wipe_req = 1'b1;
    @(posedge clk);
    #1;
    wipe_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midwipe_busy_before_reset", {311'b0, busy}, 312'd1);
    rst_n = 1'b0;
    #1;
    chk("midwipe_reset_state", {309'b0, busy, done, coll}, 312'b100);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_wipe(1'b0, bc, edges, cs);
    chk("midwipe_edges_to_done", 312'(edges), 312'd32);
    chk("midwipe_busy_samples", 312'(bc), 312'd31);
    @(posedge clk);
    #1;
    chk("midwipe_done_one_cycle", {310'b0, busy, done}, 312'd0);

    // Depth 24, three read ports: out-of-range row is neither stored nor aliased.
    chk("small_idle", {311'b0, s_busy}, 312'd0);
    @(negedge clk);
    s_addr_a = 5'd30; s_en_a = 8'hFF; s_data_a = {312{1'b1}};
    s_addr_b = 5'd4;  s_en_b = 8'hFF; s_data_b = {8{LB}};
    @(posedge clk);
    #1;
    s_en_a = '0;
    s_en_b = '0;
    s_rd_addr[0] = 5'd30;
    s_rd_addr[1] = 5'd4;
    s_rd_addr[2] = 5'd4;
    #1;
    chk("small_rd30_p0", s_rd_data[0], '0);
    chk("small_row4_p1", s_rd_data[1], {8{LB}});
    chk("small_row4_p2", s_rd_data[2], {8{LB}});
    s_rd_addr[1] = 5'd6;
    s_rd_addr[2] = 5'd30;
    #1;
    chk("small_row6_untouched", s_rd_data[1], '0);
    chk("small_rd30_p2", s_rd_data[2], '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
